// File: rtl/muldiv_ctrl_if.sv
// Bundle of every signal between the HI/LO controller, the execute stage
// and the shift-add multiplier.
//   CPU side : op_valid, op, rs_val, rt_val -> controller
//              op_ready, stall, done, hi, lo <- controller
//   MUL side : mul_start, mul_a, mul_b      <- controller
//              mul_busy, mul_h, mul_l       -> controller
// slave  : the controller (muldiv_ctrl)
// master : its environment (execute stage plus multiplier)
interface muldiv_ctrl_if;
  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        op_ready;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_busy;
  logic [31:0] mul_h;
  logic [31:0] mul_l;

  modport slave (
    input  op_valid, op, rs_val, rt_val, mul_busy, mul_h, mul_l,
    output op_ready, stall, done, hi, lo, mul_start, mul_a, mul_b
  );

  modport master (
    output op_valid, op, rs_val, rt_val, mul_busy, mul_h, mul_l,
    input  op_ready, stall, done, hi, lo, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO controller for a 32-cycle unsigned shift-add multiplier.
// Handles MULTU/MULT/MTHI/MTLO, converts signed MULT into an unsigned
// multiply on operand magnitudes and fixes the product sign afterwards,
// owns HI/LO and stalls the pipeline while a multiply is in flight.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - muldiv_ctrl_if.slave (CPU request/result and multiplier handshake)
module muldiv_ctrl (
  input  logic           clk,
  input  logic           reset,
  muldiv_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

  localparam logic [1:0] OpMultu = 2'b00;
  localparam logic [1:0] OpMult  = 2'b01;
  localparam logic [1:0] OpMthi  = 2'b10;
  localparam logic [1:0] OpMtlo  = 2'b11;

  state_e      state_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;
  logic        mul_start_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        neg_q;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  logic [31:0] rs_abs;
  logic [31:0] rt_abs;
  logic [63:0] prod;
  logic [63:0] prod_fix;

  always_comb begin
    rs_abs   = bus.rs_val[31] ? (~bus.rs_val + 32'd1) : bus.rs_val;
    rt_abs   = bus.rt_val[31] ? (~bus.rt_val + 32'd1) : bus.rt_val;
    prod     = {bus.mul_h, bus.mul_l};
    prod_fix = neg_q ? (~prod + 64'd1) : prod;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.op_valid) begin
            unique case (bus.op)
              OpMthi: hi_q <= bus.rs_val;
              OpMtlo: lo_q <= bus.rs_val;
              OpMultu: begin
                a_q         <= bus.rs_val;
                b_q         <= bus.rt_val;
                neg_q       <= 1'b0;
                mul_start_q <= 1'b1;
                state_q     <= StStart;
              end
              OpMult: begin
                a_q         <= rs_abs;
                b_q         <= rt_abs;
                neg_q       <= bus.rs_val[31] ^ bus.rt_val[31];
                mul_start_q <= 1'b1;
                state_q     <= StStart;
              end
            endcase
          end
        end
        // Busy is not valid until the multiplier has seen the start pulse.
        StStart: state_q <= StWait;
        StWait: begin
          if (!bus.mul_busy) begin
            {hi_q, lo_q} <= prod_fix;
            done_q       <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.op_ready  = (state_q == StIdle);
  assign bus.stall     = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  muldiv_ctrl_if bus ();

  muldiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 32-cycle multiplier: loads on the edge that sees mul_start,
  // busy from that edge, busy drops after the 32nd edge counted from it.
  int unsigned mcnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mul_busy <= 1'b0;
      bus.mul_h    <= '0;
      bus.mul_l    <= '0;
      mcnt         <= 0;
    end else if (bus.mul_start) begin
      bus.mul_busy           <= 1'b1;
      {bus.mul_h, bus.mul_l} <= {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
      mcnt                   <= 31;
    end else if (bus.mul_busy) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) bus.mul_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Issue a multiply at a falling edge and follow it to completion.
  task automatic run_mul(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] eh, input logic [31:0] el);
    int n;
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.rs_val   = a;
    bus.rt_val   = b;
    @(negedge clk);
    bus.op_valid = 1'b0;
    check({tag, "_start"}, 64'(bus.mul_start), 64'd1);
    check({tag, "_mul_a"}, 64'(bus.mul_a), 64'(ea));
    check({tag, "_mul_b"}, 64'(bus.mul_b), 64'(eb));
    n = 1;
    @(negedge clk);
    check({tag, "_start_off"}, 64'(bus.mul_start), 64'd0);
    while (bus.stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_stall_cycles"}, 64'(n), 64'd33);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_hilo"}, {bus.hi, bus.lo}, {eh, el});
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int n;
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    bus.op_valid = 1'b0;
    bus.op       = 2'b00;
    bus.rs_val   = '0;
    bus.rt_val   = '0;
    repeat (3) @(negedge clk);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_ready_stall", {62'd0, bus.op_ready, bus.stall}, 64'b10);
    check("rst_done_start", {62'd0, bus.done, bus.mul_start}, 64'b00);
    check("rst_mul_ab", {bus.mul_a, bus.mul_b}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // MTHI / MTLO take effect at the acceptance edge with no stall
    bus.op_valid = 1'b1;
    bus.op       = 2'b10;
    bus.rs_val   = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
    check("mthi_stall", {62'd0, bus.stall, bus.op_ready}, 64'b01);
    bus.op     = 2'b11;
    bus.rs_val = 32'hCAFE_0001;
    @(negedge clk);
    bus.op_valid = 1'b0;
    check("mtlo_lo", 64'(bus.lo), 64'hCAFE_0001);
    check("mtlo_hi_kept", 64'(bus.hi), 64'h1234_5678);

    run_mul("multu_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'h0000_0001);
    run_mul("mult_m1x1", 2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1, 32'h1,
            32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mul("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
            32'h4000_0000, 32'h0);
    run_mul("mult_zero", 2'b01, 32'h0, 32'hFFFF_FFFB, 32'h0, 32'h5, 32'h0, 32'h0);
    run_mul("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'h7, 32'h3, 32'h7,
            32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // MTLO presented during a multiply is ignored, then accepted after done
    bus.op_valid = 1'b1;
    bus.op       = 2'b00;
    bus.rs_val   = 32'd3;
    bus.rt_val   = 32'd5;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = 2'b11;
    bus.rs_val   = 32'hAAAA_5555;
    check("mtlo_busy_ready", 64'(bus.op_ready), 64'd0);
    check("mid_mul_hilo_old", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mtlo_wait_bound", 64'(n < 100), 64'd1);
    check("multu_3x5_done", 64'(bus.done), 64'd1);
    check("multu_3x5_hilo", {bus.hi, bus.lo}, {32'h0, 32'h0000_000F});
    @(negedge clk);
    bus.op_valid = 1'b0;
    check("mtlo_after", {bus.hi, bus.lo}, {32'h0, 32'hAAAA_5555});

    // Reset mid-multiply
    bus.op_valid = 1'b1;
    bus.op       = 2'b00;
    bus.rs_val   = 32'd7;
    bus.rt_val   = 32'd9;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_stall", 64'(bus.stall), 64'd1);
    reset = 1'b0;
    #1;
    check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midrst_ready_stall", {62'd0, bus.op_ready, bus.stall}, 64'b10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_mul("multu_7x9", 2'b00, 32'd7, 32'd9, 32'd7, 32'd9, 32'h0, 32'h3F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

HI/LO controller sitting between the CPU execute stage and the 32-cycle shift-add unsigned multiplier. Accepts MULTU, MULT, MTHI and MTLO requests and drives the multiplier's start/busy handshake. Performs sign pre- and post-processing so signed MULT reuses the unsigned datapath. Owns the architectural HI/LO registers and stalls the pipeline while a multiply is in flight.

## Interface
No parameters; all widths are fixed at 32 bits (MIPS32).

- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  execute stage presents an operation this cycle
- op  in  2  operation code: 00 MULTU, 01 MULT, 10 MTHI, 11 MTLO
- rs_val  in  32  operand A, or the MTHI/MTLO source
- rt_val  in  32  operand B
- op_ready  out  1  op accepted at next edge; equals (state==IDLE)
- stall  out  1  pipeline hold; equals (state!=IDLE)
- done  out  1  one-cycle pulse the cycle after HI/LO take a multiply result
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register
- mul_start  out  1  start pulse to the multiplier
- mul_a  out  32  multiplicand to the multiplier
- mul_b  out  32  multiplier operand
- mul_busy  in  1  multiplier busy
- mul_h  in  32  multiplier high result
- mul_l  in  32  multiplier low result

## Operation
- States: IDLE, START, WAIT.
- Reset (reset=0, asynchronous) forces the following, independent of clk:
  - state=IDLE
  - hi=0, lo=0
  - done=0
  - internal operand/sign registers cleared
- Resulting reset outputs:
  - op_ready=1, stall=0
  - mul_start=0, mul_a=0, mul_b=0
- IDLE with op_valid=1:
  - op=10: hi<=rs_val; stay in IDLE.
  - op=11: lo<=rs_val; stay in IDLE.
  - op=00: latch mul_a<=rs_val, mul_b<=rt_val, neg<=0; go to START.
  - op=01: latch mul_a<=|rs_val|, mul_b<=|rt_val|, neg<=rs_val[31]^rt_val[31]; go to START.
  - |x| is the two's-complement magnitude, treated as unsigned, so |0x80000000| = 0x80000000.
- START:
  - mul_start=1 for exactly this one cycle.
  - Go to WAIT unconditionally; mul_busy is not sampled in START.
- WAIT:
  - mul_start=0.
  - While mul_busy=1, hold.
  - When mul_busy=0: capture {hi,lo} <= neg ? -{mul_h,mul_l} : {mul_h,mul_l}, using 64-bit two's-complement negation. Set done=1 for the next cycle and go to IDLE.
- mul_a and mul_b stay stable from the START cycle until the next accepted multiply.
- op_valid while not IDLE: ignored and not queued. The CPU holds the request because stall=1.
- hi/lo are never modified in START or WAIT. A read during a multiply returns the old values; the pipeline is stalled anyway.
- A negated zero product yields 0 in both registers.

## Timing
- Edge E0: multiply accepted (IDLE, op_valid).
- Cycle after E0: START, mul_start=1.
- Edge E1: multiplier loads its operands; mul_busy=1 from E1.
- Edges E2..E32: multiplier iterations.
- mul_busy falls after edge E32.
- Edge E33: WAIT sees mul_busy=0; HI/LO update at E33.
- Cycle after E33: state=IDLE, done=1, stall=0, and the next op can be accepted at E34.
- Multiply latency is 33 clock edges from acceptance to HI/LO valid; stall is high for 33 cycles.
- MTHI/MTLO take effect at the acceptance edge, with zero stall.
- Back-to-back multiplies: the second is accepted at the first cycle where op_ready=1, i.e. the cycle done=1.
- Reset low mid-multiply:
  - The controller returns to IDLE immediately with hi=lo=0.
  - The multiplier's own reset is driven from the same source (inverted at top level), so no stale busy survives.
  - The first multiply after reset release follows the normal timing.

## Test plan
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → at E33: hi=0xFFFFFFFE, lo=0x00000001. stall high exactly 33 cycles; done high one cycle.
- MULT rs=0xFFFFFFFF (-1), rt=0x00000001 → hi=0xFFFFFFFF, lo=0xFFFFFFFF.
- MULT rs=0x80000000, rt=0x80000000 → hi=0x40000000, lo=0x00000000.
- MULT rs=0x00000000, rt=0xFFFFFFFB → hi=0, lo=0.
- MTHI 0x12345678 → hi updates at the acceptance edge with stall=0.
- MTLO issued 5 cycles into a MULTU 3×5 → ignored (op_ready=0). After done: lo=0x0000000F. The re-presented MTLO 0xAAAA5555 is accepted the next cycle.
- Reset asserted 10 cycles into MULTU 7×9 → hi=lo=0, stall=0, op_ready=1 immediately. A following MULTU 7×9 gives lo=0x3F, hi=0 at the normal latency.
